// File: rtl/pulse_capture_pkg.sv
// Shared types and defaults for the pulse width/gap capture block.
// rec_t is the record layout at the default field width.
package pulse_capture_pkg;

   localparam int unsigned CntWDefault  = 16;
   localparam int unsigned DepthDefault = 4;

   typedef enum logic [1:0] {
      StIdle,
      StHigh,
      StLow
   } state_e;

   typedef struct packed {
      logic [CntWDefault-1:0] width;
      logic [CntWDefault-1:0] gap;
   } rec_t;

endpackage

// File: rtl/pulse_capture_if.sv
// Record stream from pulse_capture to its consumer (valid/ready handshake).
interface pulse_capture_if #(
   parameter int unsigned CNT_W = 16
);

   logic             rec_valid;
   logic             rec_ready;
   logic [CNT_W-1:0] rec_width;
   logic [CNT_W-1:0] rec_gap;

   modport master (
      output rec_valid,
      output rec_width,
      output rec_gap,
      input  rec_ready
   );

   modport slave (
      input  rec_valid,
      input  rec_width,
      input  rec_gap,
      output rec_ready
   );

endinterface

// File: rtl/pulse_rec_fifo.sv
// Synchronous record FIFO with registered full/empty flags.
// A push while full only lands when a pop frees the head slot in the same cycle.
module pulse_rec_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter type         data_t = logic
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  logic  pop,
   input  data_t wdata,
   output data_t rdata,
   output logic  full,
   output logic  empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   data_t         mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, empty_q;
   logic          do_push, do_pop;

   assign do_pop  = pop & ~empty_q;
   assign do_push = push & (~full_q | do_pop);

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + (AW + 1)'(1);
      end else if (do_pop && !do_push) begin
         cnt_d = cnt_q - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == (AW + 1)'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/pulse_capture.sv
// Measures high time and preceding low time of each pulse on sig_in and queues
// {width, gap} records; the first pulse after idle reports a gap of 0.
module pulse_capture
   import pulse_capture_pkg::*;
#(
   parameter int unsigned CNT_W = CntWDefault,
   parameter int unsigned DEPTH = DepthDefault
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sig_in,
   input  logic            en,
   input  logic            clr_ovf,
   output logic            overflow,
   pulse_capture_if.master rec
);

   // Same layout as rec_t, sized to this instance's CNT_W.
   typedef struct packed {
      logic [CNT_W-1:0] width;
      logic [CNT_W-1:0] gap;
   } rec_n_t;

   localparam logic [CNT_W-1:0] CntMax = '1;

   state_e           state_q, state_d;
   logic             sig_d_q;
   logic [CNT_W-1:0] width_q, width_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic [CNT_W-1:0] gap_lat_q, gap_lat_d;
   logic             ovf_q, ovf_d;
   logic             rise, fall;
   logic             push, pop, drop;
   logic             fifo_full, fifo_empty;
   rec_n_t           push_rec, head_rec;

   assign rise = sig_in & ~sig_d_q;
   assign fall = ~sig_in & sig_d_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         sig_d_q   <= 1'b0;
         width_q   <= '0;
         gap_q     <= '0;
         gap_lat_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sig_d_q   <= sig_in;
         width_q   <= width_d;
         gap_q     <= gap_d;
         gap_lat_q <= gap_lat_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (rise) state_d = StHigh;
            StHigh:  if (fall) state_d = StLow;
            StLow:   if (rise) state_d = StHigh;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      width_d   = width_q;
      gap_d     = gap_q;
      gap_lat_d = gap_lat_q;
      push      = 1'b0;
      if (!en) begin
         width_d   = '0;
         gap_d     = '0;
         gap_lat_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rise) begin
                  width_d   = CNT_W'(1);
                  gap_lat_d = '0;
               end
            end
            StHigh: begin
               if (fall) begin
                  push  = 1'b1;
                  gap_d = CNT_W'(1);
               end else if (sig_in && width_q != CntMax) begin
                  width_d = width_q + CNT_W'(1);
               end
            end
            StLow: begin
               if (rise) begin
                  gap_lat_d = gap_q;
                  width_d   = CNT_W'(1);
               end else if (!sig_in && gap_q != CntMax) begin
                  gap_d = gap_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign push_rec = '{width: width_q, gap: gap_lat_q};
   assign pop      = ~fifo_empty & rec.rec_ready;
   assign drop     = push & fifo_full & ~pop;

   // A drop in the same cycle as clr_ovf still leaves the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   pulse_rec_fifo #(
      .DEPTH  (DEPTH),
      .data_t (rec_n_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (push_rec),
      .rdata (head_rec),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rec.rec_valid = ~fifo_empty;
   assign rec.rec_width = head_rec.width;
   assign rec.rec_gap   = head_rec.gap;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture: main instance at CNT_W=16/DEPTH=4 and a
// second CNT_W=4 instance used only for saturation.
module tb_pulse_capture;

   logic clk = 1'b0;
   logic rst, en, sig_in, clr_ovf, overflow;
   logic sig_s, ovf_s;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   pulse_capture_if #(.CNT_W(16)) rec_if ();
   pulse_capture_if #(.CNT_W(4))  sat_if ();

   pulse_capture #(
      .CNT_W (16),
      .DEPTH (4)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .sig_in   (sig_in),
      .en       (en),
      .clr_ovf  (clr_ovf),
      .overflow (overflow),
      .rec      (rec_if)
   );

   pulse_capture #(
      .CNT_W (4),
      .DEPTH (4)
   ) u_sat (
      .clk      (clk),
      .rst      (rst),
      .sig_in   (sig_s),
      .en       (1'b1),
      .clr_ovf  (1'b0),
      .overflow (ovf_s),
      .rec      (sat_if)
   );

   always #25 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_rec(input string tag, input int unsigned v, input int unsigned w,
                            input int unsigned g);
      check({tag, "_valid"}, rec_if.rec_valid, v);
      check({tag, "_width"}, rec_if.rec_width, w);
      check({tag, "_gap"}, rec_if.rec_gap, g);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int n);
      sig_in = v;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; sig_in = 1'b0; sig_s = 1'b0; clr_ovf = 1'b0;
      rec_if.rec_ready = 1'b1;
      sat_if.rec_ready = 1'b1;
      tick();
      tick();
      check_rec("reset", 0, 0, 0);
      check("reset_ovf", overflow, 0);
      rst = 1'b0;

      // Basic: high 3, low 5, high 2, low -> (3,0) then (2,5)
      drive(1'b1, 3);
      check("basic_pre", rec_if.rec_valid, 0);
      drive(1'b0, 1);
      check_rec("basic_r1", 1, 3, 0);
      drive(1'b0, 1);
      check("basic_popped", rec_if.rec_valid, 0);
      drive(1'b0, 3);
      drive(1'b1, 2);
      drive(1'b0, 1);
      check_rec("basic_r2", 1, 2, 5);

      // Saturation on the 4-bit instance
      sig_s = 1'b1;
      repeat (20) tick();
      sig_s = 1'b0;
      tick();
      check("sat_valid", sat_if.rec_valid, 1);
      check("sat_width", sat_if.rec_width, 15);
      check("sat_gap", sat_if.rec_gap, 0);

      // Overflow: records (1,0)..(1,3) kept, (1,4) dropped; clr_ovf on the drop cycle
      do_reset();
      rec_if.rec_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         sig_in = 1'b1;
         tick();
         sig_in = 1'b0;
         clr_ovf = (k == 5);
         tick();
         clr_ovf = 1'b0;
         if (k == 4) check("ovf_before", overflow, 0);
         if (k == 5) check("ovf_set_wins", overflow, 1);
         repeat (k - 1) tick();
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_cleared", overflow, 0);
      rec_if.rec_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_rec($sformatf("ovf_r%0d", k), 1, 1, k);
         tick();
      end
      check("ovf_drained", rec_if.rec_valid, 0);

      // Full with simultaneous pop: (1,0) leaves, (1,4) enters
      do_reset();
      rec_if.rec_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 1);
         drive(1'b0, k);
      end
      sig_in = 1'b1;
      tick();
      sig_in = 1'b0;
      rec_if.rec_ready = 1'b1;
      tick();
      rec_if.rec_ready = 1'b0;
      check("fullpop_ovf", overflow, 0);
      rec_if.rec_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check_rec($sformatf("fullpop_r%0d", k), 1, 1, k);
         tick();
      end
      check("fullpop_drained", rec_if.rec_valid, 0);

      // en dropped mid-pulse: that pulse vanishes, next reports gap 0
      do_reset();
      rec_if.rec_ready = 1'b1;
      drive(1'b1, 2);
      en = 1'b0;
      tick();
      en = 1'b1;
      drive(1'b1, 2);
      drive(1'b0, 1);
      check("en_no_rec", rec_if.rec_valid, 0);
      drive(1'b0, 2);
      drive(1'b1, 4);
      drive(1'b0, 1);
      check_rec("en_next", 1, 4, 0);

      // Reset with records queued and a pulse in progress
      do_reset();
      rec_if.rec_ready = 1'b0;
      drive(1'b1, 2);
      drive(1'b0, 2);
      drive(1'b1, 3);
      drive(1'b0, 1);
      check_rec("mr_head", 1, 2, 0);
      drive(1'b1, 2);
      do_reset();
      check("mr_flushed", rec_if.rec_valid, 0);
      drive(1'b0, 3);
      check("mr_no_fall_rec", rec_if.rec_valid, 0);

      // High right after reset release counts as a rise
      sig_in = 1'b1;
      do_reset();
      drive(1'b1, 2);
      drive(1'b0, 1);
      check_rec("post_rst_rise", 1, 2, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
